mips_multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the MIPS datapath. It succeeds the fixed-sequence controller, and adds the following:
- configurable memory latency;
- lw/sw, beq/bne and j support;
- funct-decoded R-type ALU operations;
- a sticky illegal-instruction trap.

It sits between the instruction register (opcode/funct) and ALU zero flag on one side, and every datapath load enable and mux select on the other.

---
 rtl/mips_ctrl_pkg.sv | 81 ++++++++
 rtl/mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multicycle controller: state encoding,
// instruction field constants, mux codes and the registered control bundle.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_INIT_SP, S_FETCH, S_IR_LOAD, S_DECODE, S_EXEC_R, S_EXEC_I,
    S_WB_R, S_WB_I, S_ADDR, S_MEM_RD, S_WB_LD, S_MEM_WR, S_BRANCH, S_JUMP,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_A      = 1'b1;
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM4   = 2'd3;
  localparam logic [1:0] PCIN_ALU    = 2'd0;
  localparam logic [1:0] PCIN_ALUOUT = 2'd1;
  localparam logic [1:0] PCIN_JUMP   = 2'd2;
  localparam logic [1:0] IORD_PC     = 2'd0;
  localparam logic [1:0] IORD_ALUOUT = 2'd1;
  localparam logic [1:0] RDST_RT     = 2'd0;
  localparam logic [1:0] RDST_RD     = 2'd1;
  localparam logic [1:0] RDST_SP     = 2'd2;
  localparam logic       MDAT_B      = 1'b0;
  localparam logic [2:0] M2R_MDR     = 3'd0;
  localparam logic [2:0] M2R_ALUOUT  = 3'd1;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;

  typedef struct packed {
    logic       pc_load;
    logic       mem_write;
    logic       ins_load;
    logic       reg_write;
    logic       regA_load;
    logic       regB_load;
    logic       aluout_load;
    logic       memdata;
    logic       alusrcA;
    logic [1:0] pcin;
    logic [1:0] IorD;
    logic [1:0] regdst;
    logic [1:0] alusrcB;
    logic [2:0] mem2reg;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // R-type funct to ALU operation; ALU_NONE marks an unsupported funct.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with parametrised memory latency and a sticky
// illegal-instruction trap. Outputs are registered from the next state, except
// the branch PC load which must follow the live ALU zero flag during BRANCH.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT    = 3,
  parameter int SP_INIT_SEL = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_load,
  output logic       mem_write,
  output logic       ins_load,
  output logic       reg_write,
  output logic       regA_load,
  output logic       regB_load,
  output logic       aluout_load,
  output logic       mux_memdata,
  output logic       mux_alusrcA,
  output logic [1:0] mux_pcin,
  output logic [1:0] mux_IorD,
  output logic [1:0] mux_regdst,
  output logic [1:0] mux_alusrcB,
  output logic [2:0] mux_mem2reg,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [4:0] state_o
);

  localparam int             CW       = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_WAIT - 1);

  state_t        state, nxt;
  ctrl_t         c_q, c_d;
  logic [CW-1:0] cnt;
  logic          started;
  logic [5:0]    op_q;
  logic          cnt_done, is_mem, br_take;

  assign is_mem   = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign cnt_done = (cnt == CNT_LAST);
  assign br_take  = (state == S_BRANCH) && (zero ^ (op_q == OP_BNE));

  // State and output registers; started holds IDLE for one edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      c_q     <= '0;
      started <= 1'b0;
    end else begin
      state   <= nxt;
      c_q     <= c_d;
      started <= 1'b1;
    end
  end

  // Memory wait counter: cleared on any state change, counts inside memory states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (nxt != state)  cnt <= '0;
    else if (is_mem)        cnt <= cnt + 1'b1;
  end

  // Opcode captured in DECODE so ADDR and BRANCH don't depend on a live IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_q <= '0;
    else if (state == S_DECODE)  op_q <= opcode;
  end

  // Next-state decision.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (started) nxt = S_INIT_SP;
      S_INIT_SP: nxt = S_FETCH;
      S_FETCH:   if (cnt_done) nxt = S_IR_LOAD;
      S_IR_LOAD: nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = S_EXEC_R;
          OP_ADDI:      nxt = S_EXEC_I;
          OP_LW, OP_SW: nxt = S_ADDR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:  nxt = (funct_alu(funct) == ALU_NONE) ? S_TRAP : S_WB_R;
      S_EXEC_I:  nxt = S_WB_I;
      S_WB_R:    nxt = S_FETCH;
      S_WB_I:    nxt = S_FETCH;
      S_ADDR:    nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (cnt_done) nxt = S_WB_LD;
      S_WB_LD:   nxt = S_FETCH;
      S_MEM_WR:  if (cnt_done) nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
      S_TRAP:    nxt = S_TRAP;
      default:   nxt = S_IDLE;
    endcase
  end

  // Control values for the state being entered, loaded on the same edge.
  always_comb begin
    c_d = '0;
    case (nxt)
      S_INIT_SP: begin
        c_d.reg_write = 1'b1;
        c_d.regdst    = RDST_SP;
        c_d.mem2reg   = 3'(SP_INIT_SEL);
      end
      S_FETCH:   c_d.IorD = IORD_PC;
      S_IR_LOAD: begin
        c_d.ins_load = 1'b1;
        c_d.pc_load  = 1'b1;
        c_d.pcin     = PCIN_ALU;
        c_d.alusrcA  = SRCA_PC;
        c_d.alusrcB  = SRCB_4;
        c_d.alu_op   = ALU_ADD;
      end
      S_DECODE: begin
        c_d.regA_load   = 1'b1;
        c_d.regB_load   = 1'b1;
        c_d.aluout_load = 1'b1;
        c_d.alusrcA     = SRCA_PC;
        c_d.alusrcB     = SRCB_IMM4;
        c_d.alu_op      = ALU_ADD;
      end
      S_EXEC_R: begin
        c_d.aluout_load = 1'b1;
        c_d.alusrcA     = SRCA_A;
        c_d.alusrcB     = SRCB_B;
        c_d.alu_op      = funct_alu(funct);
      end
      S_EXEC_I, S_ADDR: begin
        c_d.aluout_load = 1'b1;
        c_d.alusrcA     = SRCA_A;
        c_d.alusrcB     = SRCB_IMM;
        c_d.alu_op      = ALU_ADD;
      end
      S_WB_R: begin
        c_d.reg_write = 1'b1;
        c_d.regdst    = RDST_RD;
        c_d.mem2reg   = M2R_ALUOUT;
      end
      S_WB_I: begin
        c_d.reg_write = 1'b1;
        c_d.regdst    = RDST_RT;
        c_d.mem2reg   = M2R_ALUOUT;
      end
      S_MEM_RD:  c_d.IorD = IORD_ALUOUT;
      S_WB_LD: begin
        c_d.reg_write = 1'b1;
        c_d.regdst    = RDST_RT;
        c_d.mem2reg   = M2R_MDR;
      end
      S_MEM_WR: begin
        c_d.IorD      = IORD_ALUOUT;
        c_d.mem_write = 1'b1;
        c_d.memdata   = MDAT_B;
      end
      S_BRANCH: begin
        c_d.alusrcA = SRCA_A;
        c_d.alusrcB = SRCB_B;
        c_d.alu_op  = ALU_SUB;
        c_d.pcin    = PCIN_ALUOUT;
      end
      S_JUMP: begin
        c_d.pc_load = 1'b1;
        c_d.pcin    = PCIN_JUMP;
      end
      S_TRAP:    c_d.illegal = 1'b1;
      default:   c_d = '0;
    endcase
  end

  assign pc_load     = c_q.pc_load | br_take;
  assign mem_write   = c_q.mem_write;
  assign ins_load    = c_q.ins_load;
  assign reg_write   = c_q.reg_write;
  assign regA_load   = c_q.regA_load;
  assign regB_load   = c_q.regB_load;
  assign aluout_load = c_q.aluout_load;
  assign mux_memdata = c_q.memdata;
  assign mux_alusrcA = c_q.alusrcA;
  assign mux_pcin    = c_q.pcin;
  assign mux_IorD    = c_q.IorD;
  assign mux_regdst  = c_q.regdst;
  assign mux_alusrcB = c_q.alusrcB;
  assign mux_mem2reg = c_q.mem2reg;
  assign alu_op      = c_q.alu_op;
  assign illegal     = c_q.illegal;
  assign state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: three instances (MEM_WAIT = 3, 1, 4) each
// driven as if by an instruction register, checked cycle by cycle against a
// per-instruction phase-sequence model.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] st;
    logic       ill;
    logic [2:0] aluop;
    logic [2:0] m2r;
    logic [1:0] srcb, rdst, iord, pcin;
    logic       srca, mdat, alo, rb, ra, rw, il, mw, pcl;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cyc;
    string      nm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic [5:0] opc   [3];
  logic [5:0] fnc   [3];
  logic       zr    [3];
  obs_t       obs   [3];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  function automatic int w_of(int d);
    return (d == 0) ? 3 : ((d == 1) ? 1 : 4);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic       pcl, mw, il, rw, ra, rb, alo, mdat, srca, ill;
    logic [1:0] pcin, iord, rdst, srcb;
    logic [2:0] m2r, aluop;
    logic [4:0] st;
    mips_multicycle_ctrl #(.MEM_WAIT((gi == 0) ? 3 : ((gi == 1) ? 1 : 4)), .SP_INIT_SEL(6)) u_dut (
      .clk(clk), .rst_n(rst_n[gi]), .opcode(opc[gi]), .funct(fnc[gi]), .zero(zr[gi]),
      .pc_load(pcl), .mem_write(mw), .ins_load(il), .reg_write(rw),
      .regA_load(ra), .regB_load(rb), .aluout_load(alo),
      .mux_memdata(mdat), .mux_alusrcA(srca), .mux_pcin(pcin), .mux_IorD(iord),
      .mux_regdst(rdst), .mux_alusrcB(srcb), .mux_mem2reg(m2r), .alu_op(aluop),
      .illegal(ill), .state_o(st));
    assign obs[gi] = '{st: st, ill: ill, aluop: aluop, m2r: m2r, srcb: srcb, rdst: rdst,
                       iord: iord, pcin: pcin, srca: srca, mdat: mdat, alo: alo, rb: rb,
                       ra: ra, rw: rw, il: il, mw: mw, pcl: pcl};
  end

  // Reference ALU decode of the R-type funct field.
  function automatic logic [2:0] tb_alu(logic [5:0] fn);
    case (fn)
      6'h20: return 3'd1;
      6'h22: return 3'd2;
      6'h24: return 3'd3;
      6'h25: return 3'd4;
      6'h2A: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs while occupying state s.
  function automatic obs_t mk(state_t s, logic [2:0] a, logic take);
    obs_t o;
    o = '0;
    o.st = s;
    case (s)
      S_INIT_SP: begin o.rw = 1; o.rdst = 2; o.m2r = 6; end
      S_IR_LOAD: begin o.il = 1; o.pcl = 1; o.srcb = 1; o.aluop = 1; end
      S_DECODE:  begin o.ra = 1; o.rb = 1; o.alo = 1; o.srcb = 3; o.aluop = 1; end
      S_EXEC_R:  begin o.alo = 1; o.srca = 1; o.aluop = a; end
      S_EXEC_I, S_ADDR: begin o.alo = 1; o.srca = 1; o.srcb = 2; o.aluop = 1; end
      S_WB_R:    begin o.rw = 1; o.rdst = 1; o.m2r = 1; end
      S_WB_I:    begin o.rw = 1; o.m2r = 1; end
      S_MEM_RD:  o.iord = 1;
      S_WB_LD:   o.rw = 1;
      S_MEM_WR:  begin o.iord = 1; o.mw = 1; end
      S_BRANCH:  begin o.srca = 1; o.aluop = 2; o.pcin = 1; o.pcl = take; end
      S_JUMP:    begin o.pcl = 1; o.pcin = 2; end
      S_TRAP:    o.ill = 1;
      default:   ;
    endcase
    return o;
  endfunction

  task automatic chk_obs(string nm, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // IR fields are valid only in DECODE/EXEC_R, zero only in BRANCH; noise elsewhere.
  task automatic drive(int d, int k, logic [5:0] op, logic [5:0] fn, logic z);
    int w = w_of(d);
    if (k == w + 1 || k == w + 2) begin
      opc[d] = op; fnc[d] = fn;
    end else begin
      opc[d] = 6'($urandom); fnc[d] = 6'($urandom);
    end
    zr[d] = (k == w + 2) ? z : 1'($urandom);
  endtask

  // Reset, check IDLE hold and the INIT_SP cycle; returns at FETCH cycle 0.
  task automatic do_reset(int d);
    rst_n[d] = 1'b0;
    #1 chk_obs($sformatf("d%0d rst", d), obs[d], mk(S_IDLE, 0, 0));
    @(negedge clk) rst_n[d] = 1'b1;
    @(posedge clk) #1 chk_obs($sformatf("d%0d idle1", d), obs[d], mk(S_IDLE, 0, 0));
    @(posedge clk) #1 chk_obs($sformatf("d%0d init_sp", d), obs[d], mk(S_INIT_SP, 0, 0));
    @(posedge clk);
  endtask

  // Execute one instruction starting in FETCH cycle 0; cyc = measured length.
  task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input string tag, output int cyc);
    int   w = w_of(d);
    obs_t q[$];
    bit   trap = 0;
    repeat (w) q.push_back(mk(S_FETCH, 0, 0));
    q.push_back(mk(S_IR_LOAD, 0, 0));
    q.push_back(mk(S_DECODE, 0, 0));
    case (op)
      6'h00: begin
        q.push_back(mk(S_EXEC_R, tb_alu(fn), 0));
        if (tb_alu(fn) == 0) trap = 1;
        else q.push_back(mk(S_WB_R, 0, 0));
      end
      6'h08: begin q.push_back(mk(S_EXEC_I, 0, 0)); q.push_back(mk(S_WB_I, 0, 0)); end
      6'h23: begin
        q.push_back(mk(S_ADDR, 0, 0));
        repeat (w) q.push_back(mk(S_MEM_RD, 0, 0));
        q.push_back(mk(S_WB_LD, 0, 0));
      end
      6'h2B: begin
        q.push_back(mk(S_ADDR, 0, 0));
        repeat (w) q.push_back(mk(S_MEM_WR, 0, 0));
      end
      6'h04: q.push_back(mk(S_BRANCH, 0, z));
      6'h05: q.push_back(mk(S_BRANCH, 0, !z));
      6'h02: q.push_back(mk(S_JUMP, 0, 0));
      default: trap = 1;
    endcase
    if (trap) repeat (20) q.push_back(mk(S_TRAP, 0, 0));
    cyc = q.size() + 1;
    for (int k = 0; k < 60; k++) begin
      #1 drive(d, k, op, fn, z);
      #1;
      if (!trap && k >= w && obs[d].st == 5'(S_FETCH)) begin cyc = k; break; end
      if (k >= int'(q.size())) begin cyc = trap ? k : k + 1; break; end
      chk_obs($sformatf("d%0d %s k%0d", d, tag, k), obs[d], q[k]);
      @(posedge clk);
    end
    if (!trap) chk_int($sformatf("d%0d %s len", d, tag), cyc, q.size());
  endtask

  function automatic bit legal_op(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [13];
    int         cyc;
    logic [5:0] op, fn;
    logic [5:0] rfn [5];

    tbl[0]  = '{6'h08, 6'h00, 1'b0, 7,  "addi"};
    tbl[1]  = '{6'h00, 6'h22, 1'b0, 7,  "sub"};
    tbl[2]  = '{6'h00, 6'h20, 1'b1, 7,  "add"};
    tbl[3]  = '{6'h00, 6'h24, 1'b0, 7,  "and"};
    tbl[4]  = '{6'h00, 6'h25, 1'b0, 7,  "or"};
    tbl[5]  = '{6'h00, 6'h2A, 1'b0, 7,  "slt"};
    tbl[6]  = '{6'h23, 6'h11, 1'b0, 10, "lw"};
    tbl[7]  = '{6'h2B, 6'h07, 1'b0, 9,  "sw"};
    tbl[8]  = '{6'h04, 6'h00, 1'b1, 6,  "beq_z1"};
    tbl[9]  = '{6'h04, 6'h00, 1'b0, 6,  "beq_z0"};
    tbl[10] = '{6'h05, 6'h00, 1'b1, 6,  "bne_z1"};
    tbl[11] = '{6'h05, 6'h00, 1'b0, 6,  "bne_z0"};
    tbl[12] = '{6'h02, 6'h00, 1'b0, 6,  "j"};
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; opc[d] = '0; fnc[d] = '0; zr[d] = 1'b0;
    end
    #12;

    // Directed table on MEM_WAIT=3, then an R-type funct trap.
    do_reset(0);
    for (int i = 0; i < 13; i++) begin
      run_instr(0, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].nm, cyc);
      chk_int({"cpi ", tbl[i].nm}, cyc, tbl[i].cyc);
    end
    run_instr(0, 6'h00, 6'h3F, 1'b0, "rtrap", cyc);
    do_reset(0);
    run_instr(0, 6'h3F, 6'h20, 1'b0, "optrap", cyc);
    rst_n[0] = 1'b0;

    // lw length at the latency extremes.
    do_reset(1);
    run_instr(1, 6'h23, 6'h00, 1'b0, "lw_w1", cyc);
    chk_int("cpi lw_w1", cyc, 6);
    rst_n[1] = 1'b0;
    do_reset(2);
    run_instr(2, 6'h23, 6'h00, 1'b0, "lw_w4", cyc);
    chk_int("cpi lw_w4", cyc, 12);

    // Asynchronous reset in the middle of a MEM_WR dwell.
    for (int k = 0; k < 8; k++) begin
      #1 drive(2, k, 6'h2B, 6'h00, 1'b0);
      @(posedge clk);
    end
    #1 drive(2, 8, 6'h2B, 6'h00, 1'b0);
    #1 chk_obs("midwr pre", obs[2], mk(S_MEM_WR, 0, 0));
    #2 rst_n[2] = 1'b0;
    #1 chk_obs("midwr rst", obs[2], mk(S_IDLE, 0, 0));
    rst_n[2] = 1'b1;
    @(posedge clk);

    // Random legal instruction streams on every latency, ending in a trap.
    for (int d = 0; d < 3; d++) begin
      do_reset(d);
      for (int i = 0; i < 25; i++) begin
        case ($urandom_range(0, 6))
          0: op = 6'h00;
          1: op = 6'h08;
          2: op = 6'h23;
          3: op = 6'h2B;
          4: op = 6'h04;
          5: op = 6'h05;
          default: op = 6'h02;
        endcase
        fn = (op == 6'h00) ? rfn[$urandom_range(0, 4)] : 6'($urandom);
        run_instr(d, op, fn, 1'($urandom), $sformatf("rnd%0d", i), cyc);
      end
      op = 6'($urandom);
      while (legal_op(op)) op = 6'($urandom);
      run_instr(d, op, 6'($urandom), 1'($urandom), "rndtrap", cyc);
      rst_n[d] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
